// File: rtl/muntjac_fetch_seq.sv
// Fetch sequencer: issues word-aligned I$ requests from the fetch PC, drops stale
// responses after a redirect and hands one tagged 32-bit word per handshake to the aligner.
module muntjac_fetch_seq #(
    parameter int unsigned MaxOutstanding = 2
) (
    input  logic        clk_i,
    input  logic        rst_ni,

    input  logic        redirect_valid_i,
    input  logic [63:0] redirect_pc_i,
    input  logic [3:0]  redirect_reason_i,

    output logic        icache_req_valid_o,
    input  logic        icache_req_ready_i,
    output logic [63:0] icache_req_pc_o,

    input  logic        icache_resp_valid_i,
    input  logic [31:0] icache_resp_instr_i,
    input  logic        icache_resp_exception_i,
    input  logic [3:0]  icache_resp_ex_code_i,

    output logic        out_valid_o,
    input  logic        out_ready_i,
    output logic [63:0] out_pc_o,
    output logic [1:0]  out_strb_o,
    output logic [31:0] out_instr_o,
    output logic        out_exception_o,
    output logic [3:0]  out_ex_code_o,
    output logic [3:0]  out_reason_o
);

    localparam int unsigned CntW = $clog2(MaxOutstanding + 1);
    localparam int unsigned PtrW = (MaxOutstanding > 1) ? $clog2(MaxOutstanding) : 1;
    localparam logic [CntW-1:0] MaxCnt = CntW'(MaxOutstanding);
    localparam logic [3:0] IfPrefetch = 4'h0;

    typedef enum logic [1:0] {StIdle, StFetch, StHalt} state_e;

    state_e            state_q, state_d;
    logic [63:0]       fetch_pc_q, fetch_pc_d;
    logic              first_q, first_d;
    logic [63:0]       first_pc_q, first_pc_d;
    logic [3:0]        first_reason_q, first_reason_d;
    // outstanding_q counts every request in flight; discard_q is the stale subset of it.
    logic [CntW-1:0]   outstanding_q, outstanding_d;
    logic [CntW-1:0]   discard_q, discard_d;
    logic [PtrW-1:0]   meta_wptr_q, meta_wptr_d, meta_rptr_q, meta_rptr_d;
    logic [PtrW-1:0]   rq_wptr_q, rq_wptr_d, rq_rptr_q, rq_rptr_d;
    logic [CntW-1:0]   rq_count_q, rq_count_d;

    logic [63:0]       meta_pc_q     [MaxOutstanding];
    logic [1:0]        meta_strb_q   [MaxOutstanding];
    logic [3:0]        meta_reason_q [MaxOutstanding];
    logic [63:0]       rq_pc_q       [MaxOutstanding];
    logic [1:0]        rq_strb_q     [MaxOutstanding];
    logic [3:0]        rq_reason_q   [MaxOutstanding];
    logic [31:0]       rq_instr_q    [MaxOutstanding];
    logic              rq_exc_q      [MaxOutstanding];
    logic [3:0]        rq_code_q     [MaxOutstanding];

    logic [CntW:0]     credit_used;
    logic              req_fire, resp_fire, resp_drop, resp_keep;
    logic              meta_push, rq_push, rq_pop;
    logic [63:0]       req_meta_pc;
    logic [1:0]        req_meta_strb;
    logic [3:0]        req_meta_reason;

    function automatic logic [PtrW-1:0] ptr_inc(input logic [PtrW-1:0] p);
        return (p == PtrW'(MaxOutstanding - 1)) ? '0 : p + 1'b1;
    endfunction

    assign credit_used        = {1'b0, outstanding_q} + {1'b0, rq_count_q};
    assign icache_req_valid_o = (state_q == StFetch) && (credit_used < {1'b0, MaxCnt});
    assign icache_req_pc_o    = fetch_pc_q;

    assign req_fire  = icache_req_valid_o && icache_req_ready_i;
    // Responses with nothing in flight (e.g. after reset) are ignored outright.
    assign resp_fire = icache_resp_valid_i && (outstanding_q != '0);
    assign resp_drop = resp_fire && ((discard_q != '0) || redirect_valid_i);
    assign resp_keep = resp_fire && !resp_drop;
    assign meta_push = req_fire && !redirect_valid_i;
    assign rq_push   = resp_keep;

    assign out_valid_o = (rq_count_q != '0) && !redirect_valid_i;
    assign rq_pop      = out_valid_o && out_ready_i;

    assign req_meta_pc     = first_q ? first_pc_q : fetch_pc_q;
    assign req_meta_strb   = (first_q && first_pc_q[1]) ? 2'b10 : 2'b11;
    assign req_meta_reason = first_q ? first_reason_q : IfPrefetch;

    assign out_pc_o        = rq_pc_q[rq_rptr_q];
    assign out_strb_o      = rq_strb_q[rq_rptr_q];
    assign out_instr_o     = rq_instr_q[rq_rptr_q];
    assign out_exception_o = rq_exc_q[rq_rptr_q];
    assign out_ex_code_o   = rq_code_q[rq_rptr_q];
    assign out_reason_o    = rq_reason_q[rq_rptr_q];

    always_comb begin
        state_d        = state_q;
        fetch_pc_d     = fetch_pc_q;
        first_d        = first_q;
        first_pc_d     = first_pc_q;
        first_reason_d = first_reason_q;
        outstanding_d  = outstanding_q + CntW'(req_fire) - CntW'(resp_fire);
        discard_d      = discard_q;
        meta_wptr_d    = meta_wptr_q;
        meta_rptr_d    = meta_rptr_q;
        rq_wptr_d      = rq_wptr_q;
        rq_rptr_d      = rq_rptr_q;
        rq_count_d     = rq_count_q + CntW'(rq_push) - CntW'(rq_pop);

        if (resp_keep && icache_resp_exception_i) state_d = StHalt;
        if (req_fire) begin
            fetch_pc_d = fetch_pc_q + 64'd4;
            first_d    = 1'b0;
        end
        if (resp_drop && (discard_q != '0)) discard_d = discard_q - 1'b1;
        if (meta_push) meta_wptr_d = ptr_inc(meta_wptr_q);
        if (resp_keep) meta_rptr_d = ptr_inc(meta_rptr_q);
        if (rq_push)   rq_wptr_d   = ptr_inc(rq_wptr_q);
        if (rq_pop)    rq_rptr_d   = ptr_inc(rq_rptr_q);

        if (redirect_valid_i) begin
            state_d        = StFetch;
            fetch_pc_d     = {redirect_pc_i[63:2], 2'b00};
            first_d        = 1'b1;
            first_pc_d     = {redirect_pc_i[63:1], 1'b0};
            first_reason_d = redirect_reason_i;
            // Everything still in flight after this cycle is stale.
            discard_d      = outstanding_d;
            meta_wptr_d    = '0;
            meta_rptr_d    = '0;
            rq_wptr_d      = '0;
            rq_rptr_d      = '0;
            rq_count_d     = '0;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q        <= StIdle;
            fetch_pc_q     <= '0;
            first_q        <= 1'b0;
            first_pc_q     <= '0;
            first_reason_q <= '0;
            outstanding_q  <= '0;
            discard_q      <= '0;
            meta_wptr_q    <= '0;
            meta_rptr_q    <= '0;
            rq_wptr_q      <= '0;
            rq_rptr_q      <= '0;
            rq_count_q     <= '0;
        end else begin
            state_q        <= state_d;
            fetch_pc_q     <= fetch_pc_d;
            first_q        <= first_d;
            first_pc_q     <= first_pc_d;
            first_reason_q <= first_reason_d;
            outstanding_q  <= outstanding_d;
            discard_q      <= discard_d;
            meta_wptr_q    <= meta_wptr_d;
            meta_rptr_q    <= meta_rptr_d;
            rq_wptr_q      <= rq_wptr_d;
            rq_rptr_q      <= rq_rptr_d;
            rq_count_q     <= rq_count_d;
        end
    end

    always_ff @(posedge clk_i) begin
        if (meta_push) begin
            meta_pc_q[meta_wptr_q]     <= req_meta_pc;
            meta_strb_q[meta_wptr_q]   <= req_meta_strb;
            meta_reason_q[meta_wptr_q] <= req_meta_reason;
        end
        if (rq_push) begin
            rq_pc_q[rq_wptr_q]     <= meta_pc_q[meta_rptr_q];
            rq_strb_q[rq_wptr_q]   <= meta_strb_q[meta_rptr_q];
            rq_reason_q[rq_wptr_q] <= meta_reason_q[meta_rptr_q];
            rq_instr_q[rq_wptr_q]  <= icache_resp_instr_i;
            rq_exc_q[rq_wptr_q]    <= icache_resp_exception_i;
            rq_code_q[rq_wptr_q]   <= icache_resp_ex_code_i;
        end
    end

    // The credit rule on request issue keeps the response queue from overflowing.
    assert property (@(posedge clk_i) disable iff (!rst_ni) rq_push |-> (rq_count_q < MaxCnt));
    assert property (@(posedge clk_i) disable iff (!rst_ni) discard_q <= MaxCnt);

endmodule

// File: tb/tb_muntjac_fetch_seq.sv
// Directed bench for muntjac_fetch_seq with a 1-cycle-latency in-order I$ model.
module tb_muntjac_fetch_seq;

    typedef struct packed {
        logic [63:0] pc;
        logic [1:0]  strb;
        logic [31:0] instr;
        logic        exc;
        logic [3:0]  code;
        logic [3:0]  reason;
    } out_t;

    logic        clk = 1'b0;
    logic        rst_ni;
    logic        redirect_valid;
    logic [63:0] redirect_pc;
    logic [3:0]  redirect_reason;
    logic        req_valid;
    logic        req_ready;
    logic [63:0] req_pc;
    logic        resp_valid;
    logic [31:0] resp_instr;
    logic        resp_exc;
    logic [3:0]  resp_code;
    logic        out_valid;
    logic        out_ready;
    logic [63:0] out_pc;
    logic [1:0]  out_strb;
    logic [31:0] out_instr;
    logic        out_exc;
    logic [3:0]  out_code;
    logic [3:0]  out_reason;

    int          n_checks = 0;
    int          n_pass = 0;
    logic [63:0] reqs[$];
    logic [63:0] iq[$];
    out_t        outs[$];
    logic        resp_hold;
    logic [63:0] exc_pc;

    muntjac_fetch_seq #(.MaxOutstanding(2)) dut (
        .clk_i                   (clk),
        .rst_ni                  (rst_ni),
        .redirect_valid_i        (redirect_valid),
        .redirect_pc_i           (redirect_pc),
        .redirect_reason_i       (redirect_reason),
        .icache_req_valid_o      (req_valid),
        .icache_req_ready_i      (req_ready),
        .icache_req_pc_o         (req_pc),
        .icache_resp_valid_i     (resp_valid),
        .icache_resp_instr_i     (resp_instr),
        .icache_resp_exception_i (resp_exc),
        .icache_resp_ex_code_i   (resp_code),
        .out_valid_o             (out_valid),
        .out_ready_i             (out_ready),
        .out_pc_o                (out_pc),
        .out_strb_o              (out_strb),
        .out_instr_o             (out_instr),
        .out_exception_o         (out_exc),
        .out_ex_code_o           (out_code),
        .out_reason_o            (out_reason)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] instr_of(input logic [63:0] pc);
        return pc[31:0] ^ 32'h5A5A_0013;
    endfunction

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    task automatic check_out(input string tag, input int idx, input logic [63:0] pc,
                             input logic [1:0] strb, input logic [3:0] reason, input logic exc);
        check({tag, "_present"}, 64'(outs.size() > idx), 64'd1);
        if (outs.size() > idx) begin
            check({tag, "_pc"}, outs[idx].pc, pc);
            check({tag, "_strb"}, 64'(outs[idx].strb), 64'(strb));
            check({tag, "_reason"}, 64'(outs[idx].reason), 64'(reason));
            check({tag, "_instr"}, 64'(outs[idx].instr), 64'(instr_of({pc[63:2], 2'b00})));
            check({tag, "_exc"}, 64'(outs[idx].exc), 64'(exc));
            if (exc) check({tag, "_code"}, 64'(outs[idx].code), 64'hC);
        end
    endtask

    // Called just after a negedge; samples handshakes, crosses one posedge, then drives the I$.
    task automatic tick();
        logic [63:0] p;
        out_t        o;
        #1;
        if (req_valid && req_ready) begin
            reqs.push_back(req_pc);
            iq.push_back(req_pc);
        end
        if (out_valid && out_ready) begin
            o = '{pc: out_pc, strb: out_strb, instr: out_instr, exc: out_exc,
                  code: out_code, reason: out_reason};
            outs.push_back(o);
        end
        @(posedge clk);
        @(negedge clk);
        if (!resp_hold && iq.size() != 0) begin
            p          = iq.pop_front();
            resp_valid = 1'b1;
            resp_instr = instr_of(p);
            resp_exc   = (p == exc_pc);
            resp_code  = (p == exc_pc) ? 4'hC : 4'h0;
        end else begin
            resp_valid = 1'b0;
            resp_instr = '0;
            resp_exc   = 1'b0;
            resp_code  = '0;
        end
    endtask

    task automatic redirect(input logic [63:0] pc, input logic [3:0] reason);
        redirect_valid  = 1'b1;
        redirect_pc     = pc;
        redirect_reason = reason;
        tick();
        redirect_valid  = 1'b0;
        reqs.delete();
        outs.delete();
    endtask

    // Reset and idle long enough for the I$ model to drain any late responses.
    task automatic quiesce();
        resp_hold = 1'b0;
        rst_ni    = 1'b0;
        tick();
        rst_ni    = 1'b1;
        repeat (4) tick();
        reqs.delete();
        outs.delete();
    endtask

    initial begin
        rst_ni          = 1'b0;
        redirect_valid  = 1'b0;
        redirect_pc     = '0;
        redirect_reason = '0;
        req_ready       = 1'b1;
        resp_valid      = 1'b0;
        resp_instr      = '0;
        resp_exc        = 1'b0;
        resp_code       = '0;
        out_ready       = 1'b1;
        resp_hold       = 1'b0;
        exc_pc          = '1;

        // Reset state and no fetch before the first redirect.
        @(negedge clk);
        #1;
        check("rst_req_valid", 64'(req_valid), 64'd0);
        check("rst_out_valid", 64'(out_valid), 64'd0);
        rst_ni = 1'b1;
        repeat (3) tick();
        #1;
        check("idle_req_valid", 64'(req_valid), 64'd0);

        // Boot redirect to a half-word pc; I$ stalls twice, pc must hold.
        redirect(64'h1002, 4'h5);
        req_ready = 1'b0;
        #1;
        check("stall_valid", 64'(req_valid), 64'd1);
        check("stall_pc0", req_pc, 64'h1000);
        tick();
        #1;
        check("stall_pc1", req_pc, 64'h1000);
        req_ready = 1'b1;
        repeat (10) tick();
        check("boot_req0", reqs[0], 64'h1000);
        check("boot_req1", reqs[1], 64'h1004);
        check("boot_req2", reqs[2], 64'h1008);
        check_out("boot_out0", 0, 64'h1002, 2'b10, 4'h5, 1'b0);
        check_out("boot_out1", 1, 64'h1004, 2'b11, 4'h0, 1'b0);
        check_out("boot_out2", 2, 64'h1008, 2'b11, 4'h0, 1'b0);

        // Aligner backpressure: exactly two requests, then none until a pop.
        out_ready = 1'b0;
        redirect(64'h3000, 4'h6);
        repeat (10) tick();
        #1;
        check("bp_req_count", 64'(reqs.size()), 64'd2);
        check("bp_req_valid", 64'(req_valid), 64'd0);
        check("bp_out_valid", 64'(out_valid), 64'd1);
        out_ready = 1'b1;
        repeat (8) tick();
        check_out("bp_out0", 0, 64'h3000, 2'b11, 4'h6, 1'b0);
        check_out("bp_out1", 1, 64'h3004, 2'b11, 4'h0, 1'b0);
        check_out("bp_out2", 2, 64'h3008, 2'b11, 4'h0, 1'b0);

        // Two in flight, then redirect: both responses are dropped.
        quiesce();
        resp_hold = 1'b1;
        redirect(64'h5000, 4'h1);
        repeat (3) tick();
        #1;
        check("hold_req_count", 64'(reqs.size()), 64'd2);
        check("hold_req_valid", 64'(req_valid), 64'd0);
        redirect(64'h2000, 4'h3);
        resp_hold = 1'b0;
        repeat (8) tick();
        check("drop_req0", reqs[0], 64'h2000);
        check_out("drop_out0", 0, 64'h2000, 2'b11, 4'h3, 1'b0);

        // Redirect in the same cycle as a request fire and a response.
        quiesce();
        redirect(64'h6000, 4'h2);
        tick();
        redirect_valid  = 1'b1;
        redirect_pc     = 64'h7000;
        redirect_reason = 4'h7;
        tick();
        redirect_valid  = 1'b0;
        repeat (8) tick();
        check("same_req_fired", reqs[1], 64'h6004);
        check_out("same_out0", 0, 64'h7000, 2'b11, 4'h7, 1'b0);

        // Exception response halts fetch until the next redirect.
        quiesce();
        exc_pc = 64'h1008;
        redirect(64'h1000, 4'h2);
        repeat (10) tick();
        #1;
        check("exc_req_count", 64'(reqs.size()), 64'd4);
        check("exc_req_valid", 64'(req_valid), 64'd0);
        check_out("exc_out1", 1, 64'h1004, 2'b11, 4'h0, 1'b0);
        check_out("exc_out2", 2, 64'h1008, 2'b11, 4'h0, 1'b1);
        exc_pc = '1;
        redirect(64'h4000, 4'h1);
        repeat (6) tick();
        check("resume_req0", reqs[0], 64'h4000);
        check_out("resume_out0", 0, 64'h4000, 2'b11, 4'h1, 1'b0);

        // Reset with two requests in flight; their late responses must be ignored.
        quiesce();
        resp_hold = 1'b1;
        redirect(64'h8000, 4'h4);
        tick();
        #1;
        check("mid_req_valid_pre", 64'(req_valid), 64'd1);
        tick();
        rst_ni = 1'b0;
        #1;
        check("mid_rst_req_valid", 64'(req_valid), 64'd0);
        check("mid_rst_out_valid", 64'(out_valid), 64'd0);
        tick();
        rst_ni    = 1'b1;
        resp_hold = 1'b0;
        reqs.delete();
        outs.delete();
        repeat (5) tick();
        #1;
        check("late_out_count", 64'(outs.size()), 64'd0);
        check("late_req_valid", 64'(req_valid), 64'd0);
        check("late_out_valid", 64'(out_valid), 64'd0);
        redirect(64'h9000, 4'h5);
        repeat (6) tick();
        check("post_rst_req0", reqs[0], 64'h9000);
        check_out("post_rst_out0", 0, 64'h9000, 2'b11, 4'h5, 1'b0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
